// File: rtl/audio_codec_master.sv
// audio_codec_master: left-justified audio master (BCLK/LRCK generator, ADC serializer, DAC deserializer).
// Optional macro AUDIO_CODEC_MASTER_HOLD_LAST_EN: an underrun frame repeats the last transmitted pair instead of zeros.
module audio_codec_master #(
  parameter int BCLK_DIV         = 16,
  parameter int AUDIO_DATA_WIDTH = 32
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [AUDIO_DATA_WIDTH-1:0] adc_left_in,
  input  logic [AUDIO_DATA_WIDTH-1:0] adc_right_in,
  input  logic                        adc_valid,
  output logic                        adc_ready,
  output logic [AUDIO_DATA_WIDTH-1:0] dac_left_out,
  output logic [AUDIO_DATA_WIDTH-1:0] dac_right_out,
  output logic                        dac_valid,
  output logic                        underrun,
  output logic                        AUD_BCLK,
  output logic                        AUD_ADCLRCK,
  output logic                        AUD_DACLRCK,
  output logic                        AUD_ADCDAT,
  input  logic                        AUD_DACDAT
);
  localparam int W  = AUDIO_DATA_WIDTH;
  localparam int BW = $clog2(2 * W);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  state_t r_state, w_state_nx;

  logic [7:0]     r_div;
  logic           r_bclk, r_lrck, r_hold_full, r_cap_done, r_dac_valid, r_underrun;
  logic [BW-1:0]  r_bit;
  logic [2*W-1:0] r_shift, r_cap, r_hold;
  logic [W-1:0]   r_dac_l, r_dac_r;
  logic           w_tc, w_rise, w_fall, w_wrap, w_load, w_accept;
  logic [BW-1:0]  w_bit_nx;
  logic [2*W-1:0] w_fill;

  assign w_tc     = (r_state != IDLE) && (r_div == 8'(BCLK_DIV - 1));
  assign w_rise   = w_tc & ~r_bclk;
  assign w_fall   = w_tc & r_bclk;
  assign w_wrap   = w_fall && (r_bit == BW'(2 * W - 1));
  assign w_load   = (r_state == IDLE && enable) || (w_wrap && r_state == RUN);
  assign w_accept = adc_valid & ~r_hold_full;
  assign w_bit_nx = r_bit + 1'b1;

`ifdef AUDIO_CODEC_MASTER_HOLD_LAST_EN
  logic [2*W-1:0] r_last;
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) r_last <= '0;
    else if (w_load && r_hold_full) r_last <= r_hold;
  assign w_fill = r_last;
`else
  assign w_fill = '0;
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_state_nx;

  // LAST ignores enable until the frame in flight has fully drained
  always_comb begin
    w_state_nx = r_state;
    if (r_state == IDLE && enable) w_state_nx = RUN;
    else if (r_state == RUN && !enable) w_state_nx = LAST;
    else if (r_state == LAST && w_wrap) w_state_nx = IDLE;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      r_div       <= '0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_cap       <= '0;
      r_cap_done  <= 1'b0;
      r_dac_valid <= 1'b0;
      r_dac_l     <= '0;
      r_dac_r     <= '0;
      r_underrun  <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_div <= (r_state == IDLE || w_tc) ? '0 : r_div + 8'd1;
      if (w_tc) r_bclk <= ~r_bclk;
      if (w_rise) r_cap <= {r_cap[2*W-2:0], AUD_DACDAT};
      r_cap_done  <= w_rise && (r_bit == BW'(2 * W - 1));
      r_dac_valid <= r_cap_done;
      if (r_cap_done) begin
        r_dac_l <= r_cap[2*W-1:W];
        r_dac_r <= r_cap[W-1:0];
      end
      r_underrun <= w_load & ~r_hold_full;
      // a pair offered on a frame-start edge waits for the following frame
      if (w_accept) begin
        r_hold      <= {adc_left_in, adc_right_in};
        r_hold_full <= 1'b1;
      end else if (w_load) r_hold_full <= 1'b0;
      if (w_load) begin
        r_bit   <= '0;
        r_lrck  <= 1'b1;
        r_shift <= r_hold_full ? r_hold : w_fill;
      end else if (w_wrap) begin
        r_bit   <= '0;
        r_lrck  <= 1'b0;
        r_shift <= '0;
      end else if (w_fall) begin
        r_bit   <= w_bit_nx;
        r_lrck  <= w_bit_nx < BW'(W);
        r_shift <= r_shift << 1;
      end
    end

  assign adc_ready     = ~r_hold_full;
  assign dac_left_out  = r_dac_l;
  assign dac_right_out = r_dac_r;
  assign dac_valid     = r_dac_valid;
  assign underrun      = r_underrun;
  assign AUD_BCLK      = r_bclk;
  assign AUD_ADCLRCK   = r_lrck;
  assign AUD_DACLRCK   = r_lrck;
  assign AUD_ADCDAT    = r_shift[2*W-1];
endmodule

// File: tb/tb_audio_codec_master.sv
// tb_audio_codec_master: loopback scoreboard bench; a frame-level model predicts each transmitted/received pair.
module tb_audio_codec_master;
  localparam int W   = 32;
  localparam int DIV = 2;

  logic clk = 0, resetn = 0, enable = 0, adc_valid = 0;
  logic [W-1:0] adc_left_in = '0, adc_right_in = '0;
  logic adc_ready, dac_valid, underrun, bclk, adclrck, daclrck, adcdat, dacdat;
  logic [W-1:0] dac_left_out, dac_right_out;

  int total = 0, bad = 0;
  int cyc = 0, fs_cnt = 0, rise_cnt = 0, dv_cnt = 0, under_cnt = 0;
  int bitk = 0, last_rise = 0;
  logic [2*W-1:0] pend[$], exp_q[$];
  logic [2*W-1:0] last_pair = '0, cur_exp = '0, txbits = '0, pr;
  logic prev_ready = 1, prev_lrck = 0, prev_bclk = 0, prev_adcdat = 0, in_frame = 0, rise_ok = 0, fs;

  assign dacdat = adcdat;
  always #5 clk = ~clk;

  audio_codec_master #(.BCLK_DIV(DIV), .AUDIO_DATA_WIDTH(W)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable),
    .adc_left_in(adc_left_in), .adc_right_in(adc_right_in),
    .adc_valid(adc_valid), .adc_ready(adc_ready),
    .dac_left_out(dac_left_out), .dac_right_out(dac_right_out),
    .dac_valid(dac_valid), .underrun(underrun),
    .AUD_BCLK(bclk), .AUD_ADCLRCK(adclrck), .AUD_DACLRCK(daclrck),
    .AUD_ADCDAT(adcdat), .AUD_DACDAT(dacdat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bclk"}, bclk, 0);
    chk({tag, "_lrck"}, adclrck, 0);
    chk({tag, "_daclrck"}, daclrck, 0);
    chk({tag, "_adcdat"}, adcdat, 0);
    chk({tag, "_ready"}, adc_ready, 1);
    chk({tag, "_dac_valid"}, dac_valid, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_dac_left"}, dac_left_out, 0);
    chk({tag, "_dac_right"}, dac_right_out, 0);
  endtask

  function automatic int cnt_of(input int sel);
    return sel == 0 ? fs_cnt : sel == 1 ? dv_cnt : rise_cnt;
  endfunction

  task automatic wait_for(input string what, input int sel, input int n);
    for (int k = 0; k < 20000 && cnt_of(sel) < n; k++) @(negedge clk);
    if (cnt_of(sel) < n) begin
      total++; bad++;
      $display("FAIL wait_%s timeout actual=%0d required=%0d", what, cnt_of(sel), n);
    end
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    adc_left_in = l; adc_right_in = r; adc_valid = 1;
    for (int k = 0; k < 5000 && !adc_ready; k++) @(negedge clk);
    if (!adc_ready) begin
      total++; bad++;
      $display("FAIL push_timeout actual=ready0 required=ready1");
    end
    @(negedge clk);
    adc_valid = 0;
  endtask

  // monitor: frame-level model of the holding slot, underrun fill and loopback capture
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!resetn) begin
      pend.delete(); exp_q.delete();
      last_pair = '0; prev_ready = 1; prev_lrck = 0; prev_bclk = 0; prev_adcdat = 0;
      in_frame = 0; rise_ok = 0;
    end else begin
      fs = adclrck && !prev_lrck;
      chk("underrun", underrun, fs && pend.size() == 0);
      if (underrun) under_cnt++;
      if (fs) begin
        fs_cnt++;
        if (pend.size() > 0) begin
          pr = pend.pop_front();
          last_pair = pr;
        end
`ifdef AUDIO_CODEC_MASTER_HOLD_LAST_EN
        else pr = last_pair;
`else
        else pr = '0;
`endif
        exp_q.push_back(pr);
        cur_exp = pr; bitk = 0; in_frame = 1;
      end
      if (adc_valid && prev_ready) pend.push_back({adc_left_in, adc_right_in});
      chk("adc_ready", adc_ready, pend.size() == 0);
      chk("lrck_equal", daclrck, adclrck);
      if (bclk && !prev_bclk) begin
        rise_cnt++;
        chk("adcdat_on_rise", adcdat, prev_adcdat);
        chk("lrck_on_rise", adclrck, prev_lrck);
        if (rise_ok && cyc - last_rise < 20) chk("bclk_period", cyc - last_rise, 2 * DIV);
        last_rise = cyc; rise_ok = 1;
        if (in_frame) begin
          chk("lrck_slot", adclrck, bitk < W);
          txbits = {txbits[2*W-2:0], adcdat};
          if (bitk == 2 * W - 1) begin
            chk("tx_frame", txbits, cur_exp);
            in_frame = 0;
          end
          bitk++;
        end
      end
      if (dac_valid) begin
        dv_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dac_valid actual=1 required=0 (no frame pending)");
        end else begin
          pr = exp_q.pop_front();
          chk("dac_left", dac_left_out, pr[2*W-1:W]);
          chk("dac_right", dac_right_out, pr[W-1:0]);
        end
      end
      prev_ready = adc_ready; prev_lrck = adclrck; prev_bclk = bclk; prev_adcdat = adcdat;
    end
  end

  int r0, f0, d0;

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    resetn = 1;
    @(negedge clk);
    push(32'hA5A5_0001, 32'h8000_0000);
    chk("ready_after_push", adc_ready, 0);
    enable = 1;
    wait_for("fs", 0, 1);
    push(32'h1234_5678, 32'hDEAD_BEEF);
    wait_for("dv", 1, 1);
    chk("frame1_left", dac_left_out, 32'hA5A5_0001);
    chk("frame1_right", dac_right_out, 32'h8000_0000);
    wait_for("dv", 1, 2);
    chk("frame2_left", dac_left_out, 32'h1234_5678);
    chk("frame2_right", dac_right_out, 32'hDEAD_BEEF);
    wait_for("fs", 0, 3);
    chk("underrun_count", under_cnt, 1);
    wait_for("dv", 1, 3);
`ifdef AUDIO_CODEC_MASTER_HOLD_LAST_EN
    chk("frame3_left", dac_left_out, 32'h1234_5678);
    chk("frame3_right", dac_right_out, 32'hDEAD_BEEF);
`else
    chk("frame3_left", dac_left_out, 0);
    chk("frame3_right", dac_right_out, 0);
`endif
    push($urandom, $urandom);
    wait_for("fs", 0, 5);
    r0 = rise_cnt;
    wait_for("rise", 2, r0 + 10);
    enable = 0;
    wait_for("dv", 1, 5);
    r0 = rise_cnt; f0 = fs_cnt;
    repeat (300) @(negedge clk);
    chk("idle_no_edges", rise_cnt, r0);
    chk("idle_no_frame", fs_cnt, f0);
    chk("idle_dv_count", dv_cnt, 5);
    chk("idle_bclk", bclk, 0);
    chk("idle_lrck", adclrck, 0);
    chk("idle_adcdat", adcdat, 0);

    enable = 1;
    wait_for("fs", 0, 6);
    push($urandom, $urandom);
    wait_for("fs", 0, 7);
    r0 = rise_cnt;
    wait_for("rise", 2, r0 + 40);
    d0 = dv_cnt;
    resetn = 0;
    #1 chk_reset("midrst");
    repeat (3) @(negedge clk);
    chk("rst_no_dv", dv_cnt, d0);
    resetn = 1;
    wait_for("dv", 1, d0 + 1);
    chk("post_rst_left", dac_left_out, 0);
    chk("post_rst_right", dac_right_out, 0);

    f0 = fs_cnt;
    adc_valid = 1; adc_left_in = $urandom; adc_right_in = $urandom;
    for (int k = 0; k < 20000 && fs_cnt < f0 + 5; k++) begin
      @(negedge clk);
      if (adc_ready) begin
        @(negedge clk);
        adc_left_in = $urandom; adc_right_in = $urandom;
      end
    end
    adc_valid = 0;
    chk("stream_frames", fs_cnt >= f0 + 5, 1);

    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 300)) @(negedge clk);
      push($urandom, $urandom);
    end
    enable = 0;
    repeat (600) @(negedge clk);
    chk("final_frames_drained", exp_q.size(), 0);
    chk("final_bclk", bclk, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_codec_master.md
AUDIO_CODEC_MASTER -- requirements
Module: audio_codec_master

Interface
REQ-001 Parameter BCLK_DIV, default 16; CLOCK_50 cycles per BCLK half-period, legal range 2..255.
REQ-002 Parameter AUDIO_DATA_WIDTH, default 32; bits per channel slot and per sample word.
REQ-003 CLOCK_50  in  1  sole clock; all state on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  level; run frame generation while high.
REQ-006 adc_left_in, adc_right_in  in  AUDIO_DATA_WIDTH each  sample pair to serialize on AUD_ADCDAT.
REQ-007 adc_valid  in  1 / adc_ready  out  1  sample-pair handshake; transfer when both high on a CLOCK_50 edge.
REQ-008 dac_left_out, dac_right_out  out  AUDIO_DATA_WIDTH each  last captured AUD_DACDAT pair.
REQ-009 dac_valid  out  1  one-cycle pulse when a new DAC pair is presented.
REQ-010 underrun  out  1  one-cycle pulse at a frame start with no pending ADC pair.
REQ-011 AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK  out  1  bit clock and left/right clocks, driven by this block (master).
REQ-012 AUD_ADCDAT  out  1 / AUD_DACDAT  in  1  serial data toward / from the far end.

Function
REQ-013 Format SHALL be left-justified: frame = 2*AUDIO_DATA_WIDTH BCLK periods, LRCK high for left slot (bits 0..W-1), low for right slot, MSB in the first bit of each slot.
REQ-014 AUD_ADCLRCK and AUD_DACLRCK SHALL be identical.
REQ-015 States: IDLE, RUN, LAST. IDLE: BCLK=0, LRCK=0, ADCDAT=0, divider and bit counter held at 0.
REQ-016 IDLE->RUN when enable=1: same edge sets LRCK=1, bit counter=0, performs a frame-start load (REQ-019); BCLK stays low.
REQ-017 In RUN/LAST, divider counts 0..BCLK_DIV-1; at terminal count BCLK toggles. Rising toggle: shift AUD_DACDAT (sampled that cycle) into the capture register. Falling toggle: bit counter increments (wraps 2W-1 -> 0), LRCK and ADCDAT update for the new bit.
REQ-018 ADCDAT and LRCK SHALL change only on the CLOCK_50 edge of a BCLK falling toggle or the IDLE->RUN transition; never on a rising toggle.
REQ-019 Frame start (bit counter wrap or IDLE->RUN): if holding register full, load both words into the shift register and empty it; else pulse underrun and load per REQ-030.
REQ-020 Single-entry holding register: adc_ready=1 iff empty; a handshake fills it. A handshake coinciding with a frame-start load SHALL be accepted and held for the next frame.
REQ-021 After the rising toggle of bit 2W-1, the next CLOCK_50 cycle SHALL update dac_left_out/dac_right_out and pulse dac_valid; outputs hold between pulses.
REQ-022 enable=0 in RUN -> LAST; LAST completes the current frame and enters IDLE on the falling toggle ending bit 2W-1, without a frame-start load; enable re-asserted in LAST has no effect until IDLE.
REQ-023 Bit counter width SHALL be clog2(2W); divider width 8 bits.

Reset
REQ-024 resetn=0 SHALL immediately force state IDLE and: AUD_BCLK=0, LRCK=0, AUD_ADCDAT=0, adc_ready=1, dac_valid=0, underrun=0, dac_*_out=0, holding register empty.
REQ-025 Reset mid-frame SHALL discard partial capture and pending ADC data; no dac_valid for that frame.
REQ-026 Release SHALL be synchronous to CLOCK_50 edge; first RUN entry no earlier than the first edge after release.

Configuration
REQ-027 Macro AUDIO_CODEC_MASTER_HOLD_LAST_EN selects underrun fill data.
REQ-028 Defined: underrun frame retransmits the last transmitted pair (zeros if none since reset).
REQ-029 Undefined: no last-pair register exists.
REQ-030 Undefined: underrun frame transmits all zeros. underrun pulses in both builds.

Verification (W=32, BCLK_DIV=2 unless noted)
REQ-031 Reset, enable=1, push L=0xA5A5_0001 R=0x8000_0000 before start -> ADCDAT bits 1010_0101..0001 while LRCK=1 then 1 followed by 31 zeros; BCLK period 4 cycles; no underrun.
REQ-032 Loopback AUD_DACDAT<=AUD_ADCDAT, push L=0x1234_5678 R=0xDEAD_BEEF -> dac_valid once, one cycle after 64th rising BCLK, outputs equal pushed values.
REQ-033 No push after first frame -> underrun pulse at frame 2 start; frame 2 ADCDAT all zeros (macro undefined) or repeats frame 1 (macro defined).
REQ-034 Drop enable at bit 10 -> frame completes 64 bits, dac_valid pulses, then BCLK=LRCK=0, no further edges.
REQ-035 Assert resetn=0 at bit 40 -> outputs match REQ-024 same cycle; after restart, next dac_valid carries only post-reset frame data.
REQ-036 adc_valid held high continuously -> adc_ready deasserts after first accept; exactly one accept per frame start; no pair lost or duplicated over 4 frames.
